// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit bus arbiter: FSM encodings,
// common LCD command bytes and the long-command classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_GAP,
    ST_LO,
    ST_WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW2      = 8'h40;

  // Clear (0x01) and home (0x02/0x03) need the long controller wait.
  function automatic logic is_long_cmd(input logic cmd_rs, input logic [7:0] cmd_byte);
    return (!cmd_rs) && (cmd_byte[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant logic with a `last` pointer; with LCD_ARB_LOCK_EN
// defined, a locked owner keeps the bus across bytes.
module lcd_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic init_done,
  input  logic req0,
  input  logic req1,
`ifdef LCD_ARB_LOCK_EN
  input  logic lock0,
  input  logic lock1,
`endif
  output logic grant_valid,
  output logic grant_sel
);

  logic last;
  logic cand0;
  logic cand1;
  logic eligible;
`ifdef LCD_ARB_LOCK_EN
  logic owned;
  logic owner;
`endif

  // A held lock masks the other requester and overrides init_done.
  always_comb begin
    cand0    = req0;
    cand1    = req1;
    eligible = init_done;
`ifdef LCD_ARB_LOCK_EN
    if (owned) begin
      cand0    = req0 && !owner;
      cand1    = req1 && owner;
      eligible = 1'b1;
    end
`endif
    grant_valid = idle && eligible && (cand0 || cand1);
    grant_sel   = (cand0 && cand1) ? !last : cand1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant_valid) begin
      last <= grant_sel;
    end
  end

`ifdef LCD_ARB_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owned <= 1'b0;
      owner <= 1'b0;
    end else if (grant_valid) begin
      owned <= grant_sel ? lock1 : lock0;
      owner <= grant_sel;
    end
  end
`endif

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares the 4-bit HD44780 bus between two byte requesters, splitting bytes into
// nibble strobes and inserting the post-byte wait. Optional LCD_ARB_LOCK_EN adds lock0/lock1.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES  = 1,
  parameter int SHORT_WAIT = 1,
  parameter int LONG_WAIT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
`ifdef LCD_ARB_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  output logic       ack0,
  output logic       ack1,
  output logic       en,
  output logic       rs,
  output logic [3:0] data,
  output logic       busy,
  output logic       grant_id
);

  localparam int CW = 8;
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_WAIT - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_WAIT - 1);

  lcd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lo_q, lo_d;
  logic          long_q, long_d;
  logic          en_d, rs_d, ack0_d, ack1_d, busy_d, grant_id_d;
  logic [3:0]    data_d;
  logic          grant_valid, grant_sel;
  logic          sel_rs;
  logic [7:0]    sel_byte;
  logic [CW-1:0] wait_last;

  lcd_rr_arbiter u_rr (
    .clk        (clk),
    .reset      (reset),
    .idle       (state_q == ST_IDLE),
    .init_done  (init_done),
    .req0       (req0),
    .req1       (req1),
`ifdef LCD_ARB_LOCK_EN
    .lock0      (lock0),
    .lock1      (lock1),
`endif
    .grant_valid(grant_valid),
    .grant_sel  (grant_sel)
  );

  assign sel_rs    = grant_sel ? rs1 : rs0;
  assign sel_byte  = grant_sel ? byte1 : byte0;
  assign wait_last = long_q ? LONG_LAST : SHORT_LAST;

  // Outputs are computed for the next state so en/data/ack change on the transition edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    long_d     = long_q;
    en_d       = 1'b0;
    rs_d       = rs;
    data_d     = data;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    busy_d     = busy;
    grant_id_d = grant_id;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d    = ST_HI;
          cnt_d      = '0;
          lo_d       = sel_byte[3:0];
          long_d     = is_long_cmd(sel_rs, sel_byte);
          en_d       = 1'b1;
          rs_d       = sel_rs;
          data_d     = sel_byte[7:4];
          ack0_d     = !grant_sel;
          ack1_d     = grant_sel;
          busy_d     = 1'b1;
          grant_id_d = grant_sel;
        end
      end
      ST_HI: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
          en_d    = 1'b1;
          data_d  = lo_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LO: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lo_q     <= '0;
      long_q   <= 1'b0;
      en       <= 1'b0;
      rs       <= 1'b0;
      data     <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      long_q   <= long_d;
      en       <= en_d;
      rs       <= rs_d;
      data     <= data_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      busy     <= busy_d;
      grant_id <= grant_id_d;
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: directed scenarios plus random traffic
// against a per-byte schedule model. Lock scenario expectations follow LCD_ARB_LOCK_EN.
module tb_lcd_bus_arbiter;
  import lcd_pkg::*;

  localparam int EN_CYCLES    = 1;
  localparam int SHORT_WAIT   = 1;
  localparam int LONG_WAIT    = 2;
  localparam int SHORT_PERIOD = 3 * EN_CYCLES + SHORT_WAIT + 1;
  localparam int LONG_PERIOD  = 3 * EN_CYCLES + LONG_WAIT + 1;

  typedef struct packed {
    logic       ack0;
    logic       ack1;
    logic       en;
    logic       rs;
    logic [3:0] data;
    logic       busy;
    logic       grant_id;
  } obs_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] b;
    logic       lock;
  } item_t;

  logic       clk;
  logic       reset;
  logic       init_done;
  logic       req0, req1, rs0, rs1;
  logic [7:0] byte0, byte1;
  logic       lock0, lock1;
  logic       ack0, ack1, en, rs, busy, grant_id;
  logic [3:0] data;

  obs_t  exp_o;
  obs_t  sched[$];
  logic  m_last, m_owned, m_owner;
  item_t q0[$];
  item_t q1[$];
  int    obs_id[$];
  int    obs_cyc[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  lcd_bus_arbiter #(
    .EN_CYCLES (EN_CYCLES),
    .SHORT_WAIT(SHORT_WAIT),
    .LONG_WAIT (LONG_WAIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init_done(init_done),
    .req0     (req0),
    .req1     (req1),
    .rs0      (rs0),
    .rs1      (rs1),
    .byte0    (byte0),
    .byte1    (byte1),
`ifdef LCD_ARB_LOCK_EN
    .lock0    (lock0),
    .lock1    (lock1),
`endif
    .ack0     (ack0),
    .ack1     (ack1),
    .en       (en),
    .rs       (rs),
    .data     (data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(logic a0, logic a1, logic e, logic r, logic [3:0] d, logic b, logic g);
    obs_t o;
    o.ack0 = a0; o.ack1 = a1; o.en = e; o.rs = r; o.data = d; o.busy = b; o.grant_id = g;
    return o;
  endfunction

  function automatic obs_t observed();
    return mk(ack0, ack1, en, rs, data, busy, grant_id);
  endfunction

  function automatic void model_reset();
    sched.delete();
    exp_o   = '0;
    m_last  = 1'b1;
    m_owned = 1'b0;
    m_owner = 1'b0;
  endfunction

  // Predicts the bus state after the coming edge; a grant expands into a whole byte schedule.
  function automatic void model_edge();
    logic c0, c1, elig, win, r;
    logic [7:0] b;
    int w;
    if (sched.size() > 0) begin
      exp_o = sched.pop_front();
    end else begin
      c0 = req0; c1 = req1; elig = init_done;
`ifdef LCD_ARB_LOCK_EN
      if (m_owned) begin
        c0 = req0 && !m_owner; c1 = req1 && m_owner; elig = 1'b1;
      end
`endif
      if (elig && (c0 || c1)) begin
        win    = (c0 && c1) ? !m_last : c1;
        m_last = win;
        b      = win ? byte1 : byte0;
        r      = win ? rs1 : rs0;
        m_owned = win ? lock1 : lock0;
        m_owner = win;
        w = (!r && b < 8'h04) ? LONG_WAIT : SHORT_WAIT;
        exp_o = mk(!win, win, 1'b1, r, b[7:4], 1'b1, win);
        for (int i = 1; i < EN_CYCLES; i++) sched.push_back(mk(0, 0, 1, r, b[7:4], 1, win));
        for (int i = 0; i < EN_CYCLES; i++) sched.push_back(mk(0, 0, 0, r, b[7:4], 1, win));
        for (int i = 0; i < EN_CYCLES; i++) sched.push_back(mk(0, 0, 1, r, b[3:0], 1, win));
        for (int i = 0; i < w; i++)         sched.push_back(mk(0, 0, 0, r, b[3:0], 1, win));
        sched.push_back(mk(0, 0, 0, r, b[3:0], 0, win));
      end else begin
        exp_o.ack0 = 1'b0; exp_o.ack1 = 1'b0; exp_o.en = 1'b0; exp_o.busy = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input obs_t expv);
    obs_t got;
    got = observed();
    total++;
    assert (got === expv) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d: observed=%b expected=%b (ack0 ack1 en rs data busy gid)", tag, cyc, got, expv);
    end
  endtask

  task automatic checkValue(input string tag, input int got, input int expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic load_reqs();
    item_t it;
    if (!req0 && q0.size() > 0) begin
      it = q0.pop_front(); req0 = 1'b1; rs0 = it.rs; byte0 = it.b; lock0 = it.lock;
    end
    if (!req1 && q1.size() > 0) begin
      it = q1.pop_front(); req1 = 1'b1; rs1 = it.rs; byte1 = it.b; lock1 = it.lock;
    end
  endtask

  task automatic applyStimulus(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput(tag, exp_o);
    if (ack0) begin obs_id.push_back(0); obs_cyc.push_back(cyc); end
    if (ack1) begin obs_id.push_back(1); obs_cyc.push_back(cyc); end
    if (exp_o.ack0) req0 = 1'b0;
    if (exp_o.ack1) req1 = 1'b0;
    load_reqs();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0 || req1 || sched.size() > 0) && n < max_cycles) begin
      applyStimulus(tag);
      n++;
    end
    checkValue({tag, "_bound"}, int'(n < max_cycles), 1);
    repeat (2) applyStimulus({tag, "_idle"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    q0.delete(); q1.delete();
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("reset_hold", '0);
    @(negedge clk);
    reset = 1'b0;
    obs_id.delete(); obs_cyc.delete();
  endtask

  task automatic check_order(input string tag, input int exp_ids[$], input int period);
    checkValue({tag, "_count"}, obs_id.size(), exp_ids.size());
    for (int i = 0; i < obs_id.size() && i < exp_ids.size(); i++) begin
      checkValue($sformatf("%s_id%0d", tag, i), obs_id[i], exp_ids[i]);
      if (period > 0 && i > 0) checkValue($sformatf("%s_gap%0d", tag, i), obs_cyc[i] - obs_cyc[i-1], period);
    end
  endtask

  initial begin
    int exp_ids[$];
    item_t it;
    reset = 1'b1; init_done = 1'b0;
    req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
    byte0 = 8'h00; byte1 = 8'h00; lock0 = 1'b0; lock1 = 1'b0;
    do_reset();

    // init_done gating, then a data byte 0x35
    q0.push_back('{rs: 1'b1, b: 8'h35, lock: 1'b0});
    load_reqs();
    repeat (4) applyStimulus("no_init");
    checkValue("no_init_acks", obs_id.size(), 0);
    init_done = 1'b1;
    applyStimulus("grant_35");
    checkValue("grant_35_ack0", int'(ack0), 1);
    checkValue("grant_35_en", int'(en), 1);
    repeat (6) applyStimulus("byte_35");

    // clear command followed by a data byte
    obs_id.delete(); obs_cyc.delete();
    q0.push_back('{rs: 1'b0, b: LCD_CMD_CLEAR, lock: 1'b0});
    q0.push_back('{rs: 1'b1, b: 8'h41, lock: 1'b0});
    load_reqs();
    drain("clear", 40);
    exp_ids = '{0, 0};
    check_order("clear", exp_ids, LONG_PERIOD);

    // asynchronous reset while en is high
    q1.push_back('{rs: 1'b1, b: 8'hA7, lock: 1'b0});
    load_reqs();
    applyStimulus("pre_reset_grant");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("reset_async", '0);
    @(posedge clk);
    #1;
    checkOutput("reset_async_hold", '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) applyStimulus("post_reset_quiet");

    // both requesters busy from reset: strict alternation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{rs: 1'b1, b: 8'h30 + 8'(i), lock: 1'b0});
      q1.push_back('{rs: 1'b1, b: 8'h60 + 8'(i), lock: 1'b0});
    end
    load_reqs();
    drain("alternate", 80);
    exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1};
    check_order("alternate", exp_ids, SHORT_PERIOD);

    // locked multi-byte sequence against a pending requester
    do_reset();
    q0.push_back('{rs: 1'b0, b: LCD_CMD_DDRAM | LCD_ROW2 | 8'h03, lock: 1'b1});
    q0.push_back('{rs: 1'b1, b: 8'h31, lock: 1'b1});
    q0.push_back('{rs: 1'b1, b: 8'h32, lock: 1'b0});
    q1.push_back('{rs: 1'b1, b: 8'h4D, lock: 1'b0});
    q1.push_back('{rs: 1'b1, b: 8'h53, lock: 1'b0});
    load_reqs();
    drain("lock", 80);
`ifdef LCD_ARB_LOCK_EN
    exp_ids = '{0, 0, 0, 1, 1};
`else
    exp_ids = '{0, 1, 0, 1, 0};
`endif
    check_order("lock", exp_ids, 0);

    // random traffic; lock bursts always end with an unlocked byte
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 5) == 0 && (r == 0 ? (q0.size() == 0 && !req0) : (q1.size() == 0 && !req1))) begin
          int n;
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
              it.rs = 1'b0; it.b = 8'($urandom_range(0, 3));
            end else begin
              it.rs = 1'($urandom_range(0, 1)); it.b = 8'($urandom_range(0, 255));
            end
            it.lock = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (r == 0) q0.push_back(it); else q1.push_back(it);
          end
        end
      end
      load_reqs();
      if ($urandom_range(0, 29) == 0) init_done = ~init_done;
      applyStimulus("random");
    end
    init_done = 1'b1;
    drain("random_drain", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
